// File: rtl/mux.sv
// Two-input word selector with an optional registered side-channel (copy + select-change counter).
// The side-channel is built only when MUX_SIDECHAN_EN is defined.
module mux #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             sel_q,
   output logic [CNT_W-1:0] chg_cnt
);

   // Case form so an unknown select propagates X rather than merging a and b.
   always_comb begin
      out = 'x;
      case (s)
         1'b0:    out = a;
         1'b1:    out = b;
         default: out = 'x;
      endcase
   end

`ifdef MUX_SIDECHAN_EN
   logic [WIDTH-1:0] out_d;
   logic             sel_d;
   logic [CNT_W-1:0] chg_cnt_d;
   logic [CNT_W-1:0] chg_cnt_q;

   always_comb begin
      out_d     = out;
      sel_d     = s;
      chg_cnt_d = chg_cnt_q;
      if ((s != sel_q) && (chg_cnt_q != '1)) begin
         chg_cnt_d = chg_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         sel_q     <= 1'b0;
         chg_cnt_q <= '0;
      end else begin
         out_q     <= out_d;
         sel_q     <= sel_d;
         chg_cnt_q <= chg_cnt_d;
      end
   end

   assign chg_cnt = chg_cnt_q;
`else
   logic unused_clk_rst;

   assign unused_clk_rst = ^{clk, rst};
   assign out_q          = '0;
   assign sel_q          = 1'b0;
   assign chg_cnt        = '0;
`endif

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for mux; expectations follow MUX_SIDECHAN_EN so either build can be checked.
module tb_mux;
   localparam int unsigned WIDTH = 16;
   localparam int unsigned CNT_W = 8;

   typedef struct {
      string            tag;
      logic [WIDTH-1:0] out;
      logic [WIDTH-1:0] out_q;
      logic             sel_q;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [WIDTH-1:0] a   = '0;
   logic [WIDTH-1:0] b   = '0;
   logic             s   = 1'b0;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_q;
   logic             sel_q;
   logic [CNT_W-1:0] chg_cnt;

   exp_t             sb[$];
   int               n_cmp = 0;
   int               n_bad = 0;

   logic [WIDTH-1:0] m_out_q = '0;
   logic             m_sel_q = 1'b0;
   logic [CNT_W-1:0] m_cnt   = '0;

   mux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .a       (a),
      .b       (b),
      .s       (s),
      .out     (out),
      .out_q   (out_q),
      .sel_q   (sel_q),
      .chg_cnt (chg_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected values for the current inputs and model state go into the queue.
   task automatic push_exp(input string tag);
      exp_t e;
      e.tag   = tag;
      e.out   = s ? b : a;
      e.out_q = m_out_q;
      e.sel_q = m_sel_q;
      e.cnt   = m_cnt;
      sb.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'(1), 32'(0));
         return;
      end
      e = sb.pop_front();
      chk({e.tag, ".out"},     32'(out),     32'(e.out));
      chk({e.tag, ".out_q"},   32'(out_q),   32'(e.out_q));
      chk({e.tag, ".sel_q"},   32'(sel_q),   32'(e.sel_q));
      chk({e.tag, ".chg_cnt"}, 32'(chg_cnt), 32'(e.cnt));
   endtask

   // Change inputs with the clock held low; outputs checked a little later.
   task automatic drive(input string tag, input logic [WIDTH-1:0] na,
                        input logic [WIDTH-1:0] nb, input logic ns);
      a = na;
      b = nb;
      s = ns;
      push_exp(tag);
      #1;
      pop_cmp();
   endtask

   task automatic tick(input string tag);
`ifdef MUX_SIDECHAN_EN
      if (rst) begin
         m_out_q = '0;
         m_sel_q = 1'b0;
         m_cnt   = '0;
      end else begin
         m_out_q = s ? b : a;
         if ((s != m_sel_q) && (m_cnt != 8'hFF)) m_cnt = m_cnt + 8'd1;
         m_sel_q = s;
      end
`endif
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #4;
      push_exp(tag);
      pop_cmp();
      #1;
   endtask

   initial begin
      logic [CNT_W-1:0] held;
      bit               sw;

      // Reset state
      rst = 1'b1;
      drive("rst_in", 16'h0000, 16'h0000, 1'b0);
      tick("rst_edge");
      chk("rst_out_q", 32'(out_q), 32'(0));
      chk("rst_cnt", 32'(chg_cnt), 32'(0));
      rst = 1'b0;

      // Combinational select sequence, no clock
      drive("sel0", 16'h0000, 16'h0000, 1'b0);
      chk("tp_zero", 32'(out), 32'h0000);
      drive("sel1", 16'h00FF, 16'h0000, 1'b0);
      chk("tp_a_ff", 32'(out), 32'h00FF);
      drive("sel2", 16'h00FF, 16'h0000, 1'b1);
      chk("tp_b_0", 32'(out), 32'h0000);
      drive("sel3", 16'h00FF, 16'h0002, 1'b1);
      chk("tp_b_2", 32'(out), 32'h0002);
      drive("sel4", 16'h00FF, 16'h0002, 1'b0);
      chk("tp_a_back", 32'(out), 32'h00FF);

      // Registered path
      drive("reg_in", 16'h1234, 16'hABCD, 1'b1);
      tick("reg_edge");
`ifdef MUX_SIDECHAN_EN
      chk("tp_out_q", 32'(out_q), 32'hABCD);
      chk("tp_sel_q", 32'(sel_q), 32'(1));
`else
      chk("tp_out_q_off", 32'(out_q), 32'(0));
`endif

      // Reset mid-operation, out keeps following b
      rst = 1'b1;
      drive("rst_mid_in", 16'h1234, 16'hABCD, 1'b1);
      tick("rst_mid_edge");
      chk("rst_mid_out", 32'(out), 32'hABCD);
      chk("rst_mid_cnt", 32'(chg_cnt), 32'(0));

      // Reset together with a toggle: counter stays 0
      drive("rst_tog_in", 16'h1234, 16'hABCD, 1'b0);
      tick("rst_tog_edge");
      drive("rst_tog_in2", 16'h1234, 16'hABCD, 1'b1);
      tick("rst_tog_edge2");
      chk("rst_tog_cnt", 32'(chg_cnt), 32'(0));
      rst = 1'b0;

      // Toggle every cycle for 300 cycles: counter saturates
      sw = 1'b0;
      for (int i = 0; i < 300; i++) begin
         sw = ~sw;
         drive("tog_in", 16'($urandom), 16'($urandom), sw);
         tick("tog_edge");
      end
`ifdef MUX_SIDECHAN_EN
      chk("sat_cnt", 32'(chg_cnt), 32'd255);
`else
      chk("sat_cnt_off", 32'(chg_cnt), 32'(0));
`endif

      // Hold s constant: counter unchanged
      held = chg_cnt;
      for (int i = 0; i < 5; i++) begin
         drive("hold_in", 16'($urandom), 16'($urandom), sw);
         tick("hold_edge");
      end
      chk("hold_cnt", 32'(chg_cnt), 32'(m_cnt));
`ifdef MUX_SIDECHAN_EN
      chk("hold_cnt_abs", 32'(chg_cnt), 32'd255);
`endif
      if (held !== chg_cnt) chk("hold_cnt_same", 32'(chg_cnt), 32'(held));

      // Clock held low: out follows inputs, registered outputs frozen
      for (int i = 0; i < 20; i++) begin
         drive("async", 16'($urandom), 16'($urandom), 1'($urandom));
      end

      // Post-saturation reset clears the counter
      rst = 1'b1;
      tick("final_rst");
      chk("final_cnt", 32'(chg_cnt), 32'(0));
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
